// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl: EX-stage operand forwarding selects and load-use stall (load-use logic under LOAD_USE_DETECT_EN)
module ex_forward_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  hazard_stall
);
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd;
  logic                  ex_we, mem_we;
  logic [1:0]            a_nxt, b_nxt;
  logic                  bubble;
  // next selects: youngest producer (EX) beats MEM, r0 and unused operands read the register file
  always_comb begin
    a_nxt = (!id_rs_used || id_rs == '0) ? 2'b00 :
            (ex_we && ex_rd == id_rs) ? 2'b01 :
            (mem_we && mem_rd == id_rs) ? 2'b10 : 2'b00;
    b_nxt = (!id_rt_used || id_rt == '0) ? 2'b00 :
            (ex_we && ex_rd == id_rt) ? 2'b01 :
            (mem_we && mem_rd == id_rt) ? 2'b10 : 2'b00;
  end
  assign bubble = flush | hazard_stall;
`ifdef LOAD_USE_DETECT_EN
  logic ex_load;
  assign hazard_stall = ex_we & ex_load & (ex_rd != '0) &
                        ((id_rs_used & (ex_rd == id_rs)) | (id_rt_used & (ex_rd == id_rt)));
  // load flag travels with the EX record; a bubble never counts as a load
  always_ff @(posedge clk or posedge rst)
    if (rst) ex_load <= 1'b0;
    else if (!ext_stall) ex_load <= !bubble && id_mem_read;
`else
  logic unused;
  assign unused = id_mem_read;
  assign hazard_stall = 1'b0;
`endif
  // stage records and registered selects; freeze on ext_stall, bubble into EX on flush or load-use
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else if (!ext_stall) begin
      mem_rd    <= ex_rd;
      mem_we    <= ex_we;
      ex_rd     <= bubble ? '0 : id_rd;
      ex_we     <= !bubble && id_reg_write;
      fwd_a_sel <= bubble ? 2'b00 : a_nxt;
      fwd_b_sel <= bubble ? 2'b00 : b_nxt;
    end
endmodule

// File: tb/tb_ex_forward_ctrl.sv
// tb_ex_forward_ctrl: randomized and directed checks of ex_forward_ctrl against an in-flight instruction model
module tb_ex_forward_ctrl;
`ifdef LOAD_USE_DETECT_EN
  localparam bit lu_en = 1'b1;
`else
  localparam bit lu_en = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic id_rs_used = 1'b0, id_rt_used = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic ext_stall = 1'b0, flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic hazard_stall;
  int checks = 0, passed = 0;

  typedef struct { logic [4:0] rd; bit we; bit load; } instr_t;
  instr_t inflight[2];
  logic [1:0] exp_a, exp_b;

  ex_forward_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ext_stall(ext_stall), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] src_sel(logic [4:0] s, bit u);
    if (!u || s == 0) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (inflight[i].we && inflight[i].rd == s) return (i == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic bit model_haz();
    instr_t p = inflight[0];
    return lu_en && p.we && p.load && p.rd != 0 &&
           ((id_rs_used && p.rd == id_rs) || (id_rt_used && p.rd == id_rt));
  endfunction

  task automatic model_reset();
    inflight[0] = '{5'd0, 1'b0, 1'b0};
    inflight[1] = '{5'd0, 1'b0, 1'b0};
    exp_a = 2'b00;
    exp_b = 2'b00;
  endtask

  task automatic apply(input logic [4:0] rs, input bit ru, input logic [4:0] rt, input bit tu,
                       input logic [4:0] rd, input bit we, input bit ld, input bit xs, input bit fl);
    @(negedge clk);
    id_rs = rs; id_rs_used = ru; id_rt = rt; id_rt_used = tu;
    id_rd = rd; id_reg_write = we; id_mem_read = ld; ext_stall = xs; flush = fl;
    #1;
  endtask

  task automatic advance();
    bit h;
    @(posedge clk);
    h = model_haz();
    if (!ext_stall) begin
      if (flush || h) begin
        exp_a = 2'b00;
        exp_b = 2'b00;
        inflight[1] = inflight[0];
        inflight[0] = '{5'd0, 1'b0, 1'b0};
      end else begin
        exp_a = src_sel(id_rs, id_rs_used);
        exp_b = src_sel(id_rt, id_rt_used);
        inflight[1] = inflight[0];
        inflight[0] = '{id_rd, id_reg_write, id_mem_read};
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    apply(5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0); advance();
    apply(5'd3, 1, 5'd3, 1, 5'd4, 1, 1, 0, 0); advance();
    apply(5'd4, 1, 5'd4, 1, 5'd5, 1, 0, 0, 0);
    #1 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (fwd_a_sel !== 2'b00) $display("FAIL reset_a got %b exp 00", fwd_a_sel); else passed++;
    checks++;
    if (fwd_b_sel !== 2'b00) $display("FAIL reset_b got %b exp 00", fwd_b_sel); else passed++;
    checks++;
    if (hazard_stall !== 1'b0) $display("FAIL reset_haz got %b exp 0", hazard_stall); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    apply(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0); advance();
    apply(5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0); advance();
    checks++;
    if (fwd_a_sel !== 2'b01) $display("FAIL b2b_a got %b exp 01", fwd_a_sel); else passed++;
    apply(5'd0, 0, 5'd3, 1, 5'd6, 1, 0, 0, 0); advance();
    checks++;
    if (fwd_b_sel !== 2'b10) $display("FAIL b2b_b got %b exp 10", fwd_b_sel); else passed++;
  endtask

  task automatic test_double_producer();
    do_reset();
    apply(5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0); advance();
    apply(5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0); advance();
    apply(5'd5, 1, 5'd5, 1, 5'd0, 1, 0, 0, 0); advance();
    checks++;
    if (fwd_a_sel !== 2'b01) $display("FAIL dbl_a got %b exp 01", fwd_a_sel); else passed++;
    checks++;
    if (fwd_b_sel !== 2'b01) $display("FAIL dbl_b got %b exp 01", fwd_b_sel); else passed++;
    apply(5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0); advance();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) $display("FAIL r0_sel got %b exp 0000", {fwd_a_sel, fwd_b_sel}); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    apply(5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0); advance();
    apply(5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    checks++;
    if (hazard_stall !== lu_en) $display("FAIL lu_haz got %b exp %b", hazard_stall, lu_en); else passed++;
    advance();
    checks++;
    if (fwd_a_sel !== (lu_en ? 2'b00 : 2'b01)) $display("FAIL lu_bubble_a got %b exp %b", fwd_a_sel, lu_en ? 2'b00 : 2'b01); else passed++;
    apply(5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    checks++;
    if (hazard_stall !== 1'b0) $display("FAIL lu_release got %b exp 0", hazard_stall); else passed++;
    advance();
    checks++;
    if (fwd_a_sel !== 2'b10) $display("FAIL lu_dep_a got %b exp 10", fwd_a_sel); else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    apply(5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0, 0); advance();
    apply(5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0); advance();
    apply(5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 1, 1);
    checks++;
    if (hazard_stall !== lu_en) $display("FAIL sim_haz got %b exp %b", hazard_stall, lu_en); else passed++;
    advance();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) $display("FAIL sim_hold got %b exp 0100", {fwd_a_sel, fwd_b_sel}); else passed++;
    checks++;
    if (hazard_stall !== lu_en) $display("FAIL sim_haz_held got %b exp %b", hazard_stall, lu_en); else passed++;
    apply(5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1); advance();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) $display("FAIL sim_flush got %b exp 0000", {fwd_a_sel, fwd_b_sel}); else passed++;
    apply(5'd7, 1, 5'd2, 1, 5'd0, 0, 0, 0, 0);
    checks++;
    if (hazard_stall !== 1'b0) $display("FAIL sim_post_haz got %b exp 0", hazard_stall); else passed++;
    advance();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) $display("FAIL sim_post_sel got %b exp 1000", {fwd_a_sel, fwd_b_sel}); else passed++;
  endtask

  task automatic test_random();
    bit h;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
      h = model_haz();
      checks++;
      if (hazard_stall !== h) $display("FAIL rnd_haz[%0d] got %b exp %b", i, hazard_stall, h); else passed++;
      advance();
      checks++;
      if (fwd_a_sel !== exp_a) $display("FAIL rnd_a[%0d] got %b exp %b", i, fwd_a_sel, exp_a); else passed++;
      checks++;
      if (fwd_b_sel !== exp_b) $display("FAIL rnd_b[%0d] got %b exp %b", i, fwd_b_sel, exp_b); else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_double_producer();
    test_load_use();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
